// File: rtl/lsu_mm_wb_buffer.sv
// MXU result write-back buffer: deskews per-lane result bytes into 128-bit rows and writes them to RAM.
// Optional build macro LSU_MM_WB_RELU_EN clamps negative (signed) bytes to zero on the write path.
module lsu_mm_wb_buffer #(
   parameter int NUM_LANE = 16,
   parameter int BYTE_W   = 8,
   parameter int ADDR_W   = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         lsu_mm_wb_cfg_vld,
   output logic                         lsu_mm_wb_cfg_rdy,
   input  logic [3:0]                   lsu_mm_wb_cfg_row_len,
   input  logic [3:0]                   lsu_mm_wb_cfg_col_len,
   input  logic [11:0]                  lsu_mm_wb_cfg_dst_addr,
   input  logic [NUM_LANE-1:0]          lsu_mm_wb_mxu_vld,
   input  logic [NUM_LANE*BYTE_W-1:0]   lsu_mm_wb_mxu_data,
   output logic                         lsu_mm_wb_ram_write_vld,
   input  logic                         lsu_mm_wb_ram_write_rdy,
   output logic [ADDR_W-1:0]            lsu_mm_wb_ram_write_addr,
   output logic [NUM_LANE*BYTE_W-1:0]   lsu_mm_wb_ram_write_data,
   output logic [NUM_LANE-1:0]          lsu_mm_wb_ram_write_mask,
   output logic                         lsu_mm_wb_done,
   output logic                         lsu_mm_wb_ovf_err
);

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   state_t                     state;
   logic [3:0]                 row_len;
   logic [3:0]                 col_len;
   logic [ADDR_W-1:0]          dst_row;
   logic [4:0]                 wr_row;
   logic [4:0]                 lane_cnt [NUM_LANE];
   logic [BYTE_W-1:0]          row_buf  [NUM_LANE][NUM_LANE];

   logic                       cfg_fire;
   logic                       wr_fire;
   logic [4:0]                 next_row;
   logic                       next_ok;
   logic [NUM_LANE-1:0]        lane_mask;
   logic [NUM_LANE-1:0]        cap_en;
   logic [NUM_LANE-1:0]        ovf_hit;
   logic [NUM_LANE*BYTE_W-1:0] next_data;
   logic [3:0]                 unused_dst_lsb;

   assign unused_dst_lsb = lsu_mm_wb_cfg_dst_addr[3:0];

   function automatic logic [BYTE_W-1:0] out_byte(input logic [BYTE_W-1:0] b);
`ifdef LSU_MM_WB_RELU_EN
      out_byte = b[BYTE_W-1] ? '0 : b;
`else
      out_byte = b;
`endif
   endfunction

   // next_row is the row that the write register should hold after this edge.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      cfg_fire  = lsu_mm_wb_cfg_vld & lsu_mm_wb_cfg_rdy;
      wr_fire   = lsu_mm_wb_ram_write_vld & lsu_mm_wb_ram_write_rdy;
      next_row  = wr_fire ? wr_row + 5'd1 : wr_row;
      next_ok   = (next_row <= {1'b0, row_len});
      lane_mask = '0;
      cap_en    = '0;
      ovf_hit   = '0;
      next_data = '0;
      for (int i = 0; i < NUM_LANE; i++) begin
         lane_mask[i] = (4'(i) <= col_len);
         if (lane_mask[i]) begin
            if (lane_cnt[i] <= next_row) next_ok = 1'b0;
            next_data[i*BYTE_W +: BYTE_W] = out_byte(row_buf[next_row[3:0]][i]);
            if (state == ACTIVE && lsu_mm_wb_mxu_vld[i]) begin
               if (lane_cnt[i] <= {1'b0, row_len}) cap_en[i]  = 1'b1;
               else                                 ovf_hit[i] = 1'b1;
            end
         end
      end
   end

   // The k-th accepted byte on a lane lands in row k, which absorbs any lane skew.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the tile buffer is reset so no stale data from an aborted tile can leak out.
         for (int i = 0; i < NUM_LANE; i++) begin
            lane_cnt[i] <= '0;
            for (int r = 0; r < NUM_LANE; r++) row_buf[r][i] <= '0;
         end
      end else if (cfg_fire) begin
         for (int i = 0; i < NUM_LANE; i++) lane_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_LANE; i++) begin
            if (cap_en[i]) begin
               row_buf[lane_cnt[i][3:0]][i] <= lsu_mm_wb_mxu_data[i*BYTE_W +: BYTE_W];
               lane_cnt[i]                  <= lane_cnt[i] + 5'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only; always_comb above uses blocking.
      if (!rst_n) begin
         state                    <= IDLE;
         lsu_mm_wb_cfg_rdy        <= 1'b1;
         row_len                  <= '0;
         col_len                  <= '0;
         dst_row                  <= '0;
         wr_row                   <= '0;
         lsu_mm_wb_ram_write_vld  <= 1'b0;
         lsu_mm_wb_ram_write_addr <= '0;
         lsu_mm_wb_ram_write_data <= '0;
         lsu_mm_wb_ram_write_mask <= '0;
         lsu_mm_wb_done           <= 1'b0;
         lsu_mm_wb_ovf_err        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cfg_fire) begin
                  state             <= ACTIVE;
                  lsu_mm_wb_cfg_rdy <= 1'b0;
                  row_len           <= lsu_mm_wb_cfg_row_len;
                  col_len           <= lsu_mm_wb_cfg_col_len;
                  dst_row           <= lsu_mm_wb_cfg_dst_addr[11:4];
                  wr_row            <= '0;
                  lsu_mm_wb_ovf_err <= 1'b0;
               end
            end
            ACTIVE: begin
               if (|ovf_hit) lsu_mm_wb_ovf_err <= 1'b1;
               if (wr_fire) wr_row <= wr_row + 5'd1;
               if (wr_fire && wr_row == {1'b0, row_len}) begin
                  state                   <= DONE;
                  lsu_mm_wb_ram_write_vld <= 1'b0;
                  lsu_mm_wb_done          <= 1'b1;
               end else if (!lsu_mm_wb_ram_write_vld || lsu_mm_wb_ram_write_rdy) begin
                  lsu_mm_wb_ram_write_vld <= next_ok;
                  if (next_ok) begin
                     lsu_mm_wb_ram_write_addr <= dst_row + ADDR_W'(next_row);
                     lsu_mm_wb_ram_write_data <= next_data;
                     lsu_mm_wb_ram_write_mask <= lane_mask;
                  end
               end
            end
            DONE: begin
               state             <= IDLE;
               lsu_mm_wb_done    <= 1'b0;
               lsu_mm_wb_cfg_rdy <= 1'b1;
            end
            default: begin
               state             <= IDLE;
               lsu_mm_wb_cfg_rdy <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mm_wb_buffer.sv
// Self-checking bench for lsu_mm_wb_buffer: table of tile vectors driven through a write scoreboard,
// plus hand-written sequences for reset values and reset in the middle of a tile.
module tb_lsu_mm_wb_buffer;

   typedef struct {
      logic [3:0]  row_len;
      logic [3:0]  col_len;
      logic [11:0] dst;
      int          skew;
      int          stall;
      bit          extra0;
      bit          junk_hi;
      logic [15:0] exp_mask;
      bit          exp_ovf;
   } tile_vec_t;

   typedef struct {
      logic [7:0]   addr;
      logic [127:0] data;
      logic [15:0]  mask;
   } wr_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         cfg_vld = 1'b0;
   logic         cfg_rdy;
   logic [3:0]   cfg_row_len = '0;
   logic [3:0]   cfg_col_len = '0;
   logic [11:0]  cfg_dst = '0;
   logic [15:0]  mxu_vld = '0;
   logic [127:0] mxu_data = '0;
   logic         write_vld;
   logic         write_rdy = 1'b1;
   logic [7:0]   write_addr;
   logic [127:0] write_data;
   logic [15:0]  write_mask;
   logic         done;
   logic         ovf_err;

   lsu_mm_wb_buffer dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .lsu_mm_wb_cfg_vld        (cfg_vld),
      .lsu_mm_wb_cfg_rdy        (cfg_rdy),
      .lsu_mm_wb_cfg_row_len    (cfg_row_len),
      .lsu_mm_wb_cfg_col_len    (cfg_col_len),
      .lsu_mm_wb_cfg_dst_addr   (cfg_dst),
      .lsu_mm_wb_mxu_vld        (mxu_vld),
      .lsu_mm_wb_mxu_data       (mxu_data),
      .lsu_mm_wb_ram_write_vld  (write_vld),
      .lsu_mm_wb_ram_write_rdy  (write_rdy),
      .lsu_mm_wb_ram_write_addr (write_addr),
      .lsu_mm_wb_ram_write_data (write_data),
      .lsu_mm_wb_ram_write_mask (write_mask),
      .lsu_mm_wb_done           (done),
      .lsu_mm_wb_ovf_err        (ovf_err)
   );

   always #5 clk = ~clk;

   int  compared = 0;
   int  mismatched = 0;
   int  cyc = 0;
   int  t0 = 0;
   int  first_vld = -1;
   int  first_hs = -1;
   int  last_hs = -1;
   int  hs_cnt = 0;
   int  done_cnt = 0;
   bit  mon_en = 1'b0;
   wr_t sb_q[$];
   tile_vec_t tv[5];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] pat(input int k, input int i);
      return 8'(k * 16 + i);
   endfunction

   function automatic logic [7:0] exp_byte(input logic [7:0] b);
`ifdef LSU_MM_WB_RELU_EN
      return b[7] ? 8'h00 : b;
`else
      return b;
`endif
   endfunction

   // Scoreboard monitor: every cycle a write is offered it must match the oldest expected row.
   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         if (done) done_cnt++;
         if (write_vld) begin
            if (first_vld < 0) first_vld = cyc - t0;
            if (sb_q.size() == 0) begin
               check("sb_unexpected_write", 128'(write_vld), 128'(0));
            end else begin
               check("wr_addr", 128'(write_addr), 128'(sb_q[0].addr));
               check("wr_data", write_data, sb_q[0].data);
               check("wr_mask", 128'(write_mask), 128'(sb_q[0].mask));
               if (write_rdy) begin
                  void'(sb_q.pop_front());
                  if (first_hs < 0) first_hs = cyc - t0;
                  last_hs = cyc - t0;
                  hs_cnt++;
               end
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cfg_rdy"},   128'(cfg_rdy),    128'(1));
      check({tag, "_write_vld"}, 128'(write_vld),  128'(0));
      check({tag, "_addr"},      128'(write_addr), 128'(0));
      check({tag, "_data"},      write_data,       128'(0));
      check({tag, "_mask"},      128'(write_mask), 128'(0));
      check({tag, "_done"},      128'(done),       128'(0));
      check({tag, "_ovf"},       128'(ovf_err),    128'(0));
   endtask

   task automatic start_tile(input tile_vec_t v, input string tag);
      int  w;
      wr_t e;
      w = 0;
      while (!cfg_rdy && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      check({tag, "_cfg_rdy_wait"}, 128'(cfg_rdy), 128'(1));
      cfg_vld     = 1'b1;
      cfg_row_len = v.row_len;
      cfg_col_len = v.col_len;
      cfg_dst     = v.dst;
      write_rdy   = (v.stall == 0);
      @(posedge clk); #1;
      cfg_vld = 1'b0;
      check({tag, "_cfg_accept"}, 128'(cfg_rdy), 128'(0));
      check({tag, "_ovf_clear"},  128'(ovf_err), 128'(0));
      for (int r = 0; r <= int'(v.row_len); r++) begin
         e.addr = 8'(int'(v.dst[11:4]) + r);
         e.data = '0;
         for (int i = 0; i <= int'(v.col_len); i++) e.data[i*8 +: 8] = exp_byte(pat(r, i));
         e.mask = v.exp_mask;
         sb_q.push_back(e);
      end
      t0 = cyc; first_vld = -1; first_hs = -1; last_hs = -1; hs_cnt = 0; done_cnt = 0;
      mon_en = 1'b1;
   endtask

   // Lane i sees row k in cycle k + skew*i; optional junk on unused lanes and an overflow byte on lane 0.
   task automatic drive_cycle(input tile_vec_t v, input int t);
      int k;
      mxu_vld  = '0;
      mxu_data = '0;
      for (int i = 0; i < 16; i++) begin
         k = t - v.skew * i;
         if (i <= int'(v.col_len)) begin
            if (k >= 0 && k <= int'(v.row_len)) begin
               mxu_vld[i] = 1'b1;
               mxu_data[i*8 +: 8] = pat(k, i);
            end else if (v.extra0 && i == 0 && k == int'(v.row_len) + 1) begin
               mxu_vld[i] = 1'b1;
               mxu_data[i*8 +: 8] = 8'hAA;
            end
         end else if (v.junk_hi && t <= int'(v.row_len) + 2) begin
            mxu_vld[i] = 1'b1;
            mxu_data[i*8 +: 8] = 8'hEE;
         end
      end
      write_rdy = (t >= v.stall);
   endtask

   task automatic run_tile(input tile_vec_t v, input string tag);
      int post;
      int exp_vld;
      post = -1;
      start_tile(v, tag);
      for (int t = 0; t < 300; t++) begin
         drive_cycle(v, t);
         @(posedge clk); #1;
         if (done_cnt > 0) post++;
         if (post >= 1) break;
      end
      mxu_vld   = '0;
      write_rdy = 1'b1;
      exp_vld   = v.skew * int'(v.col_len) + 2;
      check({tag, "_done_pulses"},  128'(done_cnt),        128'(1));
      check({tag, "_cfg_rdy_back"}, 128'(cfg_rdy),         128'(1));
      check({tag, "_sb_empty"},     128'(sb_q.size()),     128'(0));
      check({tag, "_writes"},       128'(hs_cnt),          128'(int'(v.row_len) + 1));
      check({tag, "_ovf"},          128'(ovf_err),         128'(v.exp_ovf));
      check({tag, "_first_vld"},    128'(first_vld),       128'(exp_vld));
      check({tag, "_first_hs"},     128'(first_hs),        128'((v.stall > exp_vld) ? v.stall : exp_vld));
      check({tag, "_back_to_back"}, 128'(last_hs - first_hs), 128'(v.row_len));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      tv[0] = '{row_len: 4'd3,  col_len: 4'd3,  dst: 12'h120, skew: 0, stall: 0,  extra0: 1'b0, junk_hi: 1'b0, exp_mask: 16'h000F, exp_ovf: 1'b0};
      tv[1] = '{row_len: 4'd15, col_len: 4'd15, dst: 12'h000, skew: 1, stall: 0,  extra0: 1'b0, junk_hi: 1'b0, exp_mask: 16'hFFFF, exp_ovf: 1'b0};
      tv[2] = '{row_len: 4'd3,  col_len: 4'd3,  dst: 12'h120, skew: 0, stall: 10, extra0: 1'b0, junk_hi: 1'b0, exp_mask: 16'h000F, exp_ovf: 1'b0};
      tv[3] = '{row_len: 4'd2,  col_len: 4'd1,  dst: 12'hFE0, skew: 2, stall: 0,  extra0: 1'b1, junk_hi: 1'b0, exp_mask: 16'h0003, exp_ovf: 1'b1};
      tv[4] = '{row_len: 4'd5,  col_len: 4'd6,  dst: 12'h3A5, skew: 0, stall: 3,  extra0: 1'b0, junk_hi: 1'b1, exp_mask: 16'h007F, exp_ovf: 1'b0};

      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_tile(tv[0], "unskewed");
      run_tile(tv[1], "skew_full");
      run_tile(tv[2], "backpressure");
      run_tile(tv[3], "wrap_ovf");
      run_tile(tv[4], "hi_lanes");

      // Reset right after row 1 has been written: outputs clear asynchronously, no done follows.
      start_tile(tv[0], "midrst");
      for (int t = 0; t < 50 && hs_cnt < 2; t++) begin
         drive_cycle(tv[0], t);
         @(posedge clk); #1;
      end
      check("midrst_rows_written", 128'(hs_cnt), 128'(2));
      #2 rst_n = 1'b0;
      mxu_vld = '0;
      #1 check_reset_outputs("midrst_async");
      sb_q.delete();
      done_cnt = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("midrst_no_done", 128'(done_cnt), 128'(0));
      run_tile(tv[0], "post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
